dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single synchronous data-memory port (4-bit byte-lane write enables, word address, 32-bit data) between two requesters. Port 0 is the CPU load/store path, which delivers lane-aligned write data and byte masks. Port 1 is a secondary master, such as a program loader or DMA. Port 0 has fixed priority. A starvation counter guarantees port 1 forward progress, and port 1 may lock the port for bursts. Read data returns one cycle after grant and is routed to the requester that issued the read.

Parameters:
ADDR_W, 14, word-address width presented to the memory
STARVE_LIMIT, 8, consecutive cycles port 1 may be denied before it wins over port 0 (1..255)
LOCK_MAX, 16, maximum consecutive grants port 1 may hold under lock (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
req0  in  1  port 0 request valid
we0  in  4  port 0 byte-lane write enables (0000 = read)
addr0  in  ADDR_W  port 0 word address
wdata0  in  32  port 0 lane-aligned write data
gnt0  out  1  port 0 request accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  32  port 0 read data
req1, we1, addr1, wdata1  in  1/4/ADDR_W/32  port 1 request, same meaning as port 0
lock1  in  1  port 1 requests exclusive ownership for following cycles
gnt1, rvalid1, rdata1  out  1/1/32  port 1 grant and read return
mem_en  out  1  memory access strobe
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid one cycle after a read with mem_en=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ARB, starve_cnt=0, lock_cnt=0, rd_owner cleared.
  - rvalid0/1=0.
  - gnt0/1, mem_en and mem_we are forced 0 while rst=0.
- Grant (combinational, same cycle as request); exactly one of gnt0/gnt1 may be 1:
  - ARB: if req1 && (starve_cnt==STARVE_LIMIT || !req0), grant port 1; else if req0, grant port 0.
  - LOCK1: grant port 1 whenever req1=1. Port 0 is never granted.
- Memory outputs:
  - mem_en = gnt0|gnt1.
  - mem_we/mem_addr/mem_wdata take the winner's fields.
  - With no grant, mem_we=0000. mem_addr and mem_wdata are don't-care.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle req1=1 && gnt1=0.
  - Clears on gnt1.
  - Holds when req1=0.
- States:
  - ARB -> LOCK1 when gnt1 && lock1; lock_cnt loads 1.
  - LOCK1 -> ARB when (req1 && !lock1) (that cycle's grant still goes to port 1), or when !req1, or when lock_cnt reaches LOCK_MAX after a grant.
  - In LOCK1, lock_cnt increments on each gnt1.
  - Leaving LOCK1 due to LOCK_MAX clears starve_cnt. Port 0 then has priority in the next cycle, even if lock1 stays high.
- Read return:
  - A granted read (we==0000) sets rd_owner valid/port at the clock edge.
  - Next cycle: rvalid of the owner port = 1 and its rdata = mem_rdata. The other port's rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads alternating ports return in order, one per cycle, each to its issuer.
  - rdata of a port with rvalid=0 is don't-care.
- Requesters hold req and fields stable until granted. A drop without grant is legal and has no side effect beyond holding starve_cnt.
- Reset mid-operation:
  - A pending read return is discarded; no rvalid is issued after reset release.
  - Lock is released.
- Width: counters are 8-bit. STARVE_LIMIT and LOCK_MAX compare against the full counter value.

Test Plan:
- Only req0 read at addr 0x010, mem_rdata=0xDEADBEEF next cycle -> gnt0=1, mem_en=1, mem_we=0000; following cycle rvalid0=1, rdata0=0xDEADBEEF, rvalid1=0.
- req0 and req1 both held continuously, STARVE_LIMIT=8 -> gnt0 for cycles 0–7, gnt1 at cycle 8, starve_cnt back to 0, gnt0 resumes at cycle 9.
- Port 1 sw burst with lock1=1, LOCK_MAX=4, req0 held -> gnt1 for 4 consecutive cycles with mem_we=1111, then gnt0 the next cycle despite lock1=1.
- Alternating reads: port 0 at cycle 0, port 1 at cycle 1 (port 0 idle), mem_rdata 0x11111111 then 0x22222222 -> rvalid0 with 0x11111111 at cycle 1, rvalid1 with 0x22222222 at cycle 2.
- Port 0 store with we0=0100, wdata0=0x00AB0000 while req1 low -> mem_we=0100, mem_wdata=0x00AB0000, no rvalid next cycle.
- rst driven 0 one cycle after a granted read, asynchronously mid-cycle -> gnt/mem_en drop immediately, no rvalid after release, state ARB, next req1 alone granted immediately.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the shared synchronous data-memory port.
// The slave modport is the arbiter; the master modport is requesters and memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              req0;
  logic [3:0]        we0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [31:0]       rdata0;

  logic              req1;
  logic [3:0]        we1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata1;
  logic              lock1;
  logic              gnt1;
  logic              rvalid1;
  logic [31:0]       rdata1;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority data-memory arbiter: port 0 wins, port 1 is protected by a
// starvation counter and may lock the memory for bounded bursts.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);
  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  typedef enum logic {ARB, LOCK1} state_e;

  state_e     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic [7:0] lock_q, lock_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_port_q, rd_port_d;
  logic       gnt0, gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      starve_q  <= '0;
      lock_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lock_q    <= lock_d;
      rd_vld_q  <= rd_vld_d;
      rd_port_q <= rd_port_d;
    end
  end

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;

    // Grants are gated by reset so the memory sees no strobe while rst is low.
    if (rst) begin
      case (state_q)
        ARB: begin
          if (bus.req1 && (starve_q == SLIM || !bus.req0)) gnt1 = 1'b1;
          else if (bus.req0)                               gnt0 = 1'b1;
        end
        LOCK1:   gnt1 = bus.req1;
        default: ;
      endcase
    end

    if (gnt1)                             starve_d = '0;
    else if (bus.req1 && starve_q < SLIM) starve_d = starve_q + 8'd1;

    case (state_q)
      ARB: begin
        if (gnt1 && bus.lock1) begin
          lock_d = 8'd1;
          // A one-grant lock is already exhausted by the grant that opened it.
          if (LMAX != 8'd1) state_d = LOCK1;
        end
      end
      LOCK1: begin
        if (!bus.req1 || !bus.lock1) begin
          state_d = ARB;
        end else begin
          lock_d = lock_q + 8'd1;
          if (lock_d >= LMAX) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    rd_vld_d  = (gnt0 && bus.we0 == 4'b0000) || (gnt1 && bus.we1 == 4'b0000);
    rd_port_d = gnt1;
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_en    = gnt0 | gnt1;
  assign bus.mem_we    = gnt1 ? bus.we1 : (gnt0 ? bus.we0 : 4'b0000);
  assign bus.mem_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign bus.mem_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

  assign bus.rvalid0   = rd_vld_q & ~rd_port_q;
  assign bus.rvalid1   = rd_vld_q &  rd_port_q;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_dmem_arbiter;
  localparam int ADDR_W = 14;
  localparam int SLIM   = 8;
  localparam int LMAX   = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) dif ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(SLIM), .LOCK_MAX(LMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      16:      return 32'hDEADBEEF;
      32:      return 32'h11111111;
      48:      return 32'h22222222;
      default: return {24'hA5A5A5, 8'(i)};
    endcase
  endfunction

  // Memory: synchronous read, byte-lane writes, re-initialised during reset.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (dif.mem_en) begin
      if (dif.mem_we == 4'b0000) dif.mem_rdata <= mem[dif.mem_addr[5:0]];
      else
        for (int b = 0; b < 4; b++)
          if (dif.mem_we[b]) mem[dif.mem_addr[5:0]][8*b +: 8] <= dif.mem_wdata[8*b +: 8];
    end
  end

  // Reference model state: expected memory image, starvation age,
  // burst ownership and the one outstanding read.
  logic [31:0] shadow [64];
  int          m_starve;
  bit          m_locked;
  int          m_burst;
  bit          m_rv;
  bit          m_rp;
  logic [31:0] m_rd;
  bit          e0, e1;
  logic [3:0]  ewe;
  logic [31:0] ewd;
  logic [ADDR_W-1:0] ead;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_gnt0",    32'(dif.gnt0),    32'd0);
      chk("rst_gnt1",    32'(dif.gnt1),    32'd0);
      chk("rst_mem_en",  32'(dif.mem_en),  32'd0);
      chk("rst_mem_we",  32'(dif.mem_we),  32'd0);
      chk("rst_rvalid0", 32'(dif.rvalid0), 32'd0);
      chk("rst_rvalid1", 32'(dif.rvalid1), 32'd0);
      m_starve = 0;
      m_locked = 0;
      m_burst  = 0;
      m_rv     = 0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    end else begin
      if (m_locked) begin
        e1 = dif.req1;
        e0 = 1'b0;
      end else begin
        e1 = dif.req1 && (m_starve >= SLIM || !dif.req0);
        e0 = !e1 && dif.req0;
      end
      chk("gnt0",   32'(dif.gnt0),   32'(e0));
      chk("gnt1",   32'(dif.gnt1),   32'(e1));
      chk("mem_en", 32'(dif.mem_en), 32'(e0 | e1));
      ewe = e1 ? dif.we1 : dif.we0;
      ewd = e1 ? dif.wdata1 : dif.wdata0;
      ead = e1 ? dif.addr1 : dif.addr0;
      if (e0 || e1) begin
        chk("mem_we",    32'(dif.mem_we),   32'(ewe));
        chk("mem_addr",  32'(dif.mem_addr), 32'(ead));
        chk("mem_wdata", dif.mem_wdata,     ewd);
      end else begin
        chk("idle_mem_we", 32'(dif.mem_we), 32'd0);
      end
      chk("rvalid0", 32'(dif.rvalid0), 32'(m_rv && !m_rp));
      chk("rvalid1", 32'(dif.rvalid1), 32'(m_rv &&  m_rp));
      if (m_rv && !m_rp) chk("rdata0", dif.rdata0, m_rd);
      if (m_rv &&  m_rp) chk("rdata1", dif.rdata1, m_rd);

      m_rv = 0;
      if (e0 || e1) begin
        if (ewe == 4'b0000) begin
          m_rv = 1;
          m_rp = e1;
          m_rd = shadow[ead[5:0]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (ewe[b]) shadow[ead[5:0]][8*b +: 8] = ewd[8*b +: 8];
        end
      end
      if (e1)            m_starve = 0;
      else if (dif.req1) m_starve = (m_starve + 1 > SLIM) ? SLIM : m_starve + 1;
      if (!m_locked) begin
        if (e1 && dif.lock1 && LMAX > 1) begin
          m_locked = 1;
          m_burst  = 1;
        end
      end else if (!dif.req1 || !dif.lock1) begin
        m_locked = 0;
      end else begin
        m_burst++;
        if (m_burst >= LMAX) m_locked = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.req0 = 0; dif.we0 = 4'h0; dif.addr0 = '0; dif.wdata0 = '0;
    dif.req1 = 0; dif.we1 = 4'h0; dif.addr1 = '0; dif.wdata1 = '0;
    dif.lock1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int first;
    int n1;
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    idle_inputs();
    dif.req0 = 1;                          // grants must stay forced low in reset
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    next_cycle();

    // Single port-0 read
    dif.req0 = 1; dif.addr0 = 14'h010;
    @(negedge clk);
    chk("rd0_gnt0",   32'(dif.gnt0),   32'd1);
    chk("rd0_mem_en", 32'(dif.mem_en), 32'd1);
    chk("rd0_mem_we", 32'(dif.mem_we), 32'd0);
    next_cycle();
    dif.req0 = 0;
    @(negedge clk);
    chk("rd0_rvalid0", 32'(dif.rvalid0), 32'd1);
    chk("rd0_rdata0",  dif.rdata0,       32'hDEADBEEF);
    chk("rd0_rvalid1", 32'(dif.rvalid1), 32'd0);
    next_cycle();

    // Starvation: both held, port 1 wins once after SLIM denials
    dif.req0 = 1; dif.we0 = 4'hF; dif.addr0 = 14'h001; dif.wdata0 = 32'h01010101;
    dif.req1 = 1; dif.we1 = 4'hF; dif.addr1 = 14'h002; dif.wdata1 = 32'h02020202;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dif.gnt1 && first < 0) first = c;
      if (c == 9) chk("starve_resume_gnt0", 32'(dif.gnt0), 32'd1);
      next_cycle();
    end
    chk("starve_first_gnt1", 32'(first), 32'd8);
    idle_inputs();
    next_cycle();

    // Locked burst: LMAX grants to port 1, then port 0 despite lock1
    dif.req1 = 1; dif.lock1 = 1; dif.we1 = 4'hF; dif.addr1 = 14'h003; dif.wdata1 = 32'hCAFEF00D;
    n1 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        n1 += int'(dif.gnt1);
        chk("lock_mem_we", 32'(dif.mem_we), 32'hF);
      end else begin
        chk("lock_end_gnt0", 32'(dif.gnt0), 32'd1);
        chk("lock_end_gnt1", 32'(dif.gnt1), 32'd0);
      end
      next_cycle();
      dif.req0 = 1; dif.we0 = 4'hF; dif.addr0 = 14'h004; dif.wdata0 = 32'h44444444;
    end
    chk("lock_burst_len", 32'(n1), 32'd4);
    idle_inputs();
    next_cycle();

    // Alternating reads, each returned to its issuer
    dif.req0 = 1; dif.addr0 = 14'h020;
    @(negedge clk);
    chk("alt_gnt0", 32'(dif.gnt0), 32'd1);
    next_cycle();
    dif.req0 = 0; dif.req1 = 1; dif.addr1 = 14'h030;
    @(negedge clk);
    chk("alt_gnt1",    32'(dif.gnt1),    32'd1);
    chk("alt_rvalid0", 32'(dif.rvalid0), 32'd1);
    chk("alt_rdata0",  dif.rdata0,       32'h11111111);
    next_cycle();
    dif.req1 = 0;
    @(negedge clk);
    chk("alt_rvalid1",  32'(dif.rvalid1), 32'd1);
    chk("alt_rdata1",   dif.rdata1,       32'h22222222);
    chk("alt_rvalid0b", 32'(dif.rvalid0), 32'd0);
    next_cycle();

    // Byte store, then read back the merged word through port 1
    dif.req0 = 1; dif.we0 = 4'b0100; dif.addr0 = 14'h005; dif.wdata0 = 32'h00AB0000;
    @(negedge clk);
    chk("st_mem_we",    32'(dif.mem_we), 32'h4);
    chk("st_mem_wdata", dif.mem_wdata,   32'h00AB0000);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("st_no_rvalid0", 32'(dif.rvalid0), 32'd0);
    chk("st_no_rvalid1", 32'(dif.rvalid1), 32'd0);
    next_cycle();
    dif.req1 = 1; dif.addr1 = 14'h005;
    next_cycle();
    dif.req1 = 0;
    @(negedge clk);
    chk("st_readback", dif.rdata1, 32'hA5ABA505);
    next_cycle();

    // Asynchronous reset right after a granted read
    dif.req0 = 1; dif.addr0 = 14'h010;
    @(negedge clk);
    chk("rr_gnt0", 32'(dif.gnt0), 32'd1);
    next_cycle();
    dif.addr0 = 14'h020;
    #2 rst = 1'b0;
    #1;
    chk("rr_async_gnt0",    32'(dif.gnt0),    32'd0);
    chk("rr_async_mem_en",  32'(dif.mem_en),  32'd0);
    chk("rr_async_rvalid0", 32'(dif.rvalid0), 32'd0);
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    dif.req1 = 1; dif.addr1 = 14'h010;
    @(negedge clk);
    chk("rr_post_gnt1",    32'(dif.gnt1),    32'd1);
    chk("rr_post_rvalid0", 32'(dif.rvalid0), 32'd0);
    chk("rr_post_rvalid1", 32'(dif.rvalid1), 32'd0);
    next_cycle();
    dif.req1 = 0;
    @(negedge clk);
    chk("rr_post_rd_rvalid1", 32'(dif.rvalid1), 32'd1);
    chk("rr_post_rd_rdata1",  dif.rdata1,       32'hDEADBEEF);
    chk("rr_post_rd_rvalid0", 32'(dif.rvalid0), 32'd0);
    next_cycle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
